// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: match sequencer for the two-player VGA paddle game (state, scores, paddles, serve).
// Build option: define PONG_ATTRACT_EN to let the paddles sweep on their own while idle in QI.
`timescale 1ns/1ps
module pong_game_ctrl #(
    parameter int WIN_SCORE   = 10,
    parameter int PADDLE_INIT = 240,
    parameter int PADDLE_MIN  = 50,
    parameter int PADDLE_MAX  = 430,
    parameter int PADDLE_STEP = 4,
    parameter int SERVE_DELAY = 32
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    input  logic       miss_p1,
    input  logic       miss_p2,
    output logic [1:0] state,
    output logic [9:0] p1_pos,
    output logic [9:0] p2_pos,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       ball_en,
    output logic       serve,
    output logic [1:0] winner
);

    localparam int               CNT_W      = $clog2(SERVE_DELAY + 1);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY);
    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);
    localparam logic [9:0]       POS_INIT   = 10'(PADDLE_INIT);
    localparam logic [9:0]       POS_MIN    = 10'(PADDLE_MIN);
    localparam logic [9:0]       POS_MAX    = 10'(PADDLE_MAX);
    localparam logic [9:0]       STEP       = 10'(PADDLE_STEP);
    localparam logic [9:0]       LO_LIM     = 10'(PADDLE_MIN + PADDLE_STEP);
    localparam logic [9:0]       HI_LIM     = 10'(PADDLE_MAX - PADDLE_STEP);

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } state_t;

    state_t           state_q;
    state_t           state_nxt;
    logic [4:0]       sync_meta;
    logic [4:0]       sync_out;
    logic             start_s;
    logic             p1_up_s;
    logic             p1_dn_s;
    logic             p2_up_s;
    logic             p2_dn_s;
    logic [CNT_W-1:0] serve_cnt;
    logic [CNT_W-1:0] serve_cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [9:0]       p1_pos_nxt;
    logic [9:0]       p2_pos_nxt;
    logic [3:0]       p1_score_nxt;
    logic [3:0]       p2_score_nxt;
    logic [3:0]       p1_inc;
    logic [3:0]       p2_inc;
    logic             ball_en_nxt;
    logic             serve_nxt;
    logic [1:0]       winner_nxt;
    logic             enter_qi;
`ifdef PONG_ATTRACT_EN
    logic             p1_dir_up;
    logic             p2_dir_up;
    logic             p1_dir_nxt;
    logic             p2_dir_nxt;
`endif

    // One paddle move on a tick: up-only or down-only moves, clamped to the legal range.
    function automatic logic [9:0] paddle_step(input logic [9:0] pos, input logic up,
                                               input logic dn);
        logic [9:0] res;
        res = pos;
        if (up && !dn) begin
            res = (pos < LO_LIM) ? POS_MIN : pos - STEP;
        end else if (dn && !up) begin
            res = (pos > HI_LIM) ? POS_MAX : pos + STEP;
        end
        return res;
    endfunction

`ifdef PONG_ATTRACT_EN
    // Returns {still_moving_up, new_pos}; direction flips on touching either limit.
    function automatic logic [10:0] sweep(input logic [9:0] pos, input logic up);
        logic [10:0] res;
        if (up) begin
            res = (pos <= LO_LIM) ? {1'b0, POS_MIN} : {1'b1, pos - STEP};
        end else begin
            res = (pos >= HI_LIM) ? {1'b1, POS_MAX} : {1'b0, pos + STEP};
        end
        return res;
    endfunction
`endif

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= {start, p1_up, p1_dn, p2_up, p2_dn};
            sync_out  <= sync_meta;
        end
    end

    assign {start_s, p1_up_s, p1_dn_s, p2_up_s, p2_dn_s} = sync_out;
    assign cnt_inc = serve_cnt + 1'b1;
    assign p1_inc  = p1_score + 4'd1;
    assign p2_inc  = p2_score + 4'd1;
    assign state   = state_q;

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q <= QI;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        p1_pos_nxt    = p1_pos;
        p2_pos_nxt    = p2_pos;
        p1_score_nxt  = p1_score;
        p2_score_nxt  = p2_score;
        ball_en_nxt   = ball_en;
        serve_nxt     = 1'b0;
        winner_nxt    = winner;
        serve_cnt_nxt = serve_cnt;
        enter_qi      = 1'b0;
`ifdef PONG_ATTRACT_EN
        p1_dir_nxt    = p1_dir_up;
        p2_dir_nxt    = p2_dir_up;
`endif
        case (state_q)
            QI: begin
                ball_en_nxt = 1'b0;
                if (start_s) begin
                    state_nxt     = QGAME_1;
                    serve_cnt_nxt = '0;
                    p1_pos_nxt    = POS_INIT;
                    p2_pos_nxt    = POS_INIT;
                end
`ifdef PONG_ATTRACT_EN
                else if (tick) begin
                    {p1_dir_nxt, p1_pos_nxt} = sweep(p1_pos, p1_dir_up);
                    {p2_dir_nxt, p2_pos_nxt} = sweep(p2_pos, p2_dir_up);
                end
`endif
            end
            QGAME_1, QGAME_2: begin
                if (!start_s) begin
                    enter_qi = 1'b1;
                end else if (ball_en && (miss_p1 || miss_p2)) begin
                    // A simultaneous double miss scores nothing and the same server re-serves.
                    ball_en_nxt   = 1'b0;
                    serve_cnt_nxt = '0;
                    if (miss_p1 ^ miss_p2) begin
                        if (miss_p2) begin
                            p1_score_nxt = p1_inc;
                            if (p1_inc == WIN) begin
                                state_nxt  = QDONE;
                                winner_nxt = 2'b01;
                            end else begin
                                state_nxt = QGAME_2;
                            end
                        end else begin
                            p2_score_nxt = p2_inc;
                            if (p2_inc == WIN) begin
                                state_nxt  = QDONE;
                                winner_nxt = 2'b10;
                            end else begin
                                state_nxt = QGAME_1;
                            end
                        end
                    end
                end else begin
                    if (serve) begin
                        ball_en_nxt = 1'b1;
                    end else if (!ball_en && tick && serve_cnt != SERVE_LAST) begin
                        serve_cnt_nxt = cnt_inc;
                        serve_nxt     = (cnt_inc == SERVE_LAST);
                    end
                    if (tick) begin
                        p1_pos_nxt = paddle_step(p1_pos, p1_up_s, p1_dn_s);
                        p2_pos_nxt = paddle_step(p2_pos, p2_up_s, p2_dn_s);
                    end
                end
            end
            QDONE: begin
                ball_en_nxt = 1'b0;
                if (!start_s) begin
                    enter_qi = 1'b1;
                end
            end
            default: enter_qi = 1'b1;
        endcase

        // Every way back to idle (abort, end of match) clears the match completely.
        if (enter_qi) begin
            state_nxt     = QI;
            p1_score_nxt  = '0;
            p2_score_nxt  = '0;
            winner_nxt    = 2'b00;
            ball_en_nxt   = 1'b0;
            serve_nxt     = 1'b0;
            serve_cnt_nxt = '0;
            p1_pos_nxt    = POS_INIT;
            p2_pos_nxt    = POS_INIT;
`ifdef PONG_ATTRACT_EN
            p1_dir_nxt    = 1'b1;
            p2_dir_nxt    = 1'b0;
`endif
        end
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            p1_pos    <= POS_INIT;
            p2_pos    <= POS_INIT;
            p1_score  <= '0;
            p2_score  <= '0;
            ball_en   <= 1'b0;
            serve     <= 1'b0;
            winner    <= 2'b00;
            serve_cnt <= '0;
`ifdef PONG_ATTRACT_EN
            p1_dir_up <= 1'b1;
            p2_dir_up <= 1'b0;
`endif
        end else begin
            p1_pos    <= p1_pos_nxt;
            p2_pos    <= p2_pos_nxt;
            p1_score  <= p1_score_nxt;
            p2_score  <= p2_score_nxt;
            ball_en   <= ball_en_nxt;
            serve     <= serve_nxt;
            winner    <= winner_nxt;
            serve_cnt <= serve_cnt_nxt;
`ifdef PONG_ATTRACT_EN
            p1_dir_up <= p1_dir_nxt;
            p2_dir_up <= p2_dir_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Testbench for pong_game_ctrl: randomized rallies and paddle moves checked against a
// score/position model of the match rules.
`timescale 1ns/1ps
module tb_pong_game_ctrl;

    logic       board_clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       p1_up = 1'b0;
    logic       p1_dn = 1'b0;
    logic       p2_up = 1'b0;
    logic       p2_dn = 1'b0;
    logic       miss_p1 = 1'b0;
    logic       miss_p2 = 1'b0;
    logic [1:0] state;
    logic [9:0] p1_pos;
    logic [9:0] p2_pos;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic       ball_en;
    logic       serve;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;

    int m_s1 = 0;
    int m_s2 = 0;
    int m_server = 1;
    int m_winner = 0;
    int m_p1 = 240;
    int m_p2 = 240;
    bit m_done = 1'b0;

    pong_game_ctrl dut (
        .board_clk(board_clk),
        .reset    (reset),
        .tick     (tick),
        .start    (start),
        .p1_up    (p1_up),
        .p1_dn    (p1_dn),
        .p2_up    (p2_up),
        .p2_dn    (p2_dn),
        .miss_p1  (miss_p1),
        .miss_p2  (miss_p2),
        .state    (state),
        .p1_pos   (p1_pos),
        .p2_pos   (p2_pos),
        .p1_score (p1_score),
        .p2_score (p2_score),
        .ball_en  (ball_en),
        .serve    (serve),
        .winner   (winner)
    );

    always #5 board_clk = ~board_clk;

    // Paddle rule: one button moves 4 px, clamped to 50..430; both or neither holds.
    function automatic int model_move(input int pos, input bit up, input bit dn);
        if (up && !dn) return (pos - 4 < 50) ? 50 : pos - 4;
        if (dn && !up) return (pos + 4 > 430) ? 430 : pos + 4;
        return pos;
    endfunction

    task automatic step();
        @(posedge board_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic model_new_match();
        m_s1 = 0;
        m_s2 = 0;
        m_server = 1;
        m_winner = 0;
        m_done = 1'b0;
        m_p1 = 240;
        m_p2 = 240;
    endtask

    // 32 ticks: nothing before the 32nd, serve right after it, ball live one cycle later.
    task automatic do_serve(input bit inject);
        int early;
        early = 0;
        for (int i = 1; i <= 32; i++) begin
            pulse_tick();
            if (i < 32) begin
                if (serve || ball_en) early++;
                step();
            end
            if (inject && i == 10) begin
                miss_p1 = 1'b1;
                miss_p2 = 1'($urandom_range(0, 1));
                step();
                miss_p1 = 1'b0;
                miss_p2 = 1'b0;
                checks++;
                if ({state, p1_score, p2_score} !== {2'(m_server), 4'(m_s1), 4'(m_s2)}) begin
                    errors++;
                    $display("[TB] FAIL ignored_miss: state=%0d s1=%0d s2=%0d, expected state=%0d s1=%0d s2=%0d",
                             state, p1_score, p2_score, m_server, m_s1, m_s2);
                end
            end
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("[TB] FAIL serve_early: %0d early serve/ball_en samples, expected 0", early);
        end
        checks++;
        if ({serve, ball_en} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL serve_pulse: serve=%0d ball_en=%0d, expected serve=1 ball_en=0",
                     serve, ball_en);
        end
        step();
        checks++;
        if ({serve, ball_en, state} !== {2'b01, 2'(m_server)}) begin
            errors++;
            $display("[TB] FAIL ball_live: serve=%0d ball_en=%0d state=%0d, expected serve=0 ball_en=1 state=%0d",
                     serve, ball_en, state, m_server);
        end
    endtask

    // kind 0: player 1 misses, kind 1: player 2 misses, kind 2: both miss together.
    task automatic play_point(input int kind, input bit inject);
        int exp_state;
        do_serve(inject);
        idle($urandom_range(0, 4));
        miss_p1 = (kind == 0 || kind == 2);
        miss_p2 = (kind == 1 || kind == 2);
        step();
        miss_p1 = 1'b0;
        miss_p2 = 1'b0;
        if (kind == 1) begin
            m_s1++;
            if (m_s1 == 10) begin
                m_done = 1'b1;
                m_winner = 1;
            end else begin
                m_server = 2;
            end
        end else if (kind == 0) begin
            m_s2++;
            if (m_s2 == 10) begin
                m_done = 1'b1;
                m_winner = 2;
            end else begin
                m_server = 1;
            end
        end
        exp_state = m_done ? 3 : m_server;
        checks++;
        if ({state, p1_score, p2_score, winner, ball_en} !==
            {2'(exp_state), 4'(m_s1), 4'(m_s2), 2'(m_winner), 1'b0}) begin
            errors++;
            $display("[TB] FAIL point: state=%0d s1=%0d s2=%0d winner=%0d ball_en=%0d, expected state=%0d s1=%0d s2=%0d winner=%0d ball_en=0",
                     state, p1_score, p2_score, winner, ball_en, exp_state, m_s1, m_s2, m_winner);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        checks++;
        if ({state, ball_en, serve, winner} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: state=%0d ball_en=%0d serve=%0d winner=%0d, expected all 0",
                     state, ball_en, serve, winner);
        end
        checks++;
        if ({p1_pos, p2_pos, p1_score, p2_score} !== {10'd240, 10'd240, 8'd0}) begin
            errors++;
            $display("[TB] FAIL reset_data: p1_pos=%0d p2_pos=%0d s1=%0d s2=%0d, expected 240 240 0 0",
                     p1_pos, p2_pos, p1_score, p2_score);
        end
        #2 reset = 1'b0;
        idle(3);
        checks++;
        if ({state, p1_pos, p2_pos} !== {2'd0, 10'd240, 10'd240}) begin
            errors++;
            $display("[TB] FAIL idle_hold: state=%0d p1_pos=%0d p2_pos=%0d, expected 0 240 240",
                     state, p1_pos, p2_pos);
        end
    endtask

    task automatic test_start_serve();
        model_new_match();
        start = 1'b1;
        idle(2);
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("[TB] FAIL start_sync: state=%0d two cycles after start, expected 0", state);
        end
        step();
        checks++;
        if ({state, ball_en, serve} !== {2'd1, 2'b00}) begin
            errors++;
            $display("[TB] FAIL start_entry: state=%0d ball_en=%0d serve=%0d, expected 1 0 0",
                     state, ball_en, serve);
        end
    endtask

    task automatic test_point();
        play_point(1, 1'b0);
        play_point(2, 1'b1);
    endtask

    task automatic test_paddles();
        int n;
        bit [3:0] btn;
        p1_up = 1'b1;
        idle(3);
        repeat (60) begin
            pulse_tick();
            step();
        end
        checks++;
        if ({p1_pos, p2_pos} !== {10'd50, 10'(m_p2)}) begin
            errors++;
            $display("[TB] FAIL paddle_clamp: p1_pos=%0d p2_pos=%0d, expected 50 %0d", p1_pos, p2_pos, m_p2);
        end
        m_p1 = 50;
        p1_dn = 1'b1;
        idle(3);
        repeat (5) begin
            pulse_tick();
            step();
        end
        checks++;
        if (p1_pos !== 10'd50) begin
            errors++;
            $display("[TB] FAIL paddle_both: p1_pos=%0d, expected 50", p1_pos);
        end
        for (int seg = 0; seg < 30; seg++) begin
            btn = 4'($urandom_range(0, 15));
            {p1_up, p1_dn, p2_up, p2_dn} = btn;
            idle(3);
            n = $urandom_range(1, 30);
            repeat (n) begin
                pulse_tick();
                step();
                m_p1 = model_move(m_p1, btn[3], btn[2]);
                m_p2 = model_move(m_p2, btn[1], btn[0]);
            end
            checks++;
            if ({p1_pos, p2_pos} !== {10'(m_p1), 10'(m_p2)}) begin
                errors++;
                $display("[TB] FAIL paddle_rand: seg=%0d p1_pos=%0d p2_pos=%0d, expected %0d %0d",
                         seg, p1_pos, p2_pos, m_p1, m_p2);
            end
        end
        {p1_up, p1_dn, p2_up, p2_dn} = 4'b0;
        idle(3);
    endtask

    task automatic test_abort();
        start = 1'b0;
        idle(3);
        model_new_match();
        checks++;
        if ({state, p1_score, p2_score, ball_en, serve, p1_pos, p2_pos} !==
            {2'd0, 8'd0, 2'b00, 10'd240, 10'd240}) begin
            errors++;
            $display("[TB] FAIL abort: state=%0d s1=%0d s2=%0d ball_en=%0d serve=%0d p1=%0d p2=%0d, expected 0 0 0 0 0 240 240",
                     state, p1_score, p2_score, ball_en, serve, p1_pos, p2_pos);
        end
    endtask

    task automatic test_random_game();
        int r;
        model_new_match();
        start = 1'b1;
        idle(3);
        for (int pt = 0; pt < 80 && !m_done; pt++) begin
            r = $urandom_range(0, 9);
            play_point((r == 0) ? 2 : (r % 2), ($urandom_range(0, 3) == 0));
        end
        checks++;
        if (!m_done || state !== 2'd3) begin
            errors++;
            $display("[TB] FAIL game_end: state=%0d model_done=%0d, expected state=3", state, m_done);
        end
        p1_up = 1'b1;
        p2_dn = 1'b1;
        idle(3);
        repeat (4) begin
            pulse_tick();
            step();
        end
        miss_p2 = 1'b1;
        step();
        miss_p2 = 1'b0;
        step();
        checks++;
        if ({state, p1_score, p2_score, winner, ball_en, serve, p1_pos, p2_pos} !==
            {2'd3, 4'(m_s1), 4'(m_s2), 2'(m_winner), 2'b00, 10'(m_p1), 10'(m_p2)}) begin
            errors++;
            $display("[TB] FAIL done_frozen: state=%0d s1=%0d s2=%0d winner=%0d ball_en=%0d serve=%0d p1=%0d p2=%0d, expected 3 %0d %0d %0d 0 0 %0d %0d",
                     state, p1_score, p2_score, winner, ball_en, serve, p1_pos, p2_pos,
                     m_s1, m_s2, m_winner, m_p1, m_p2);
        end
        p1_up = 1'b0;
        p2_dn = 1'b0;
        start = 1'b0;
        idle(3);
        model_new_match();
        checks++;
        if ({state, p1_score, p2_score, winner, p1_pos, p2_pos} !==
            {2'd0, 8'd0, 2'd0, 10'd240, 10'd240}) begin
            errors++;
            $display("[TB] FAIL done_exit: state=%0d s1=%0d s2=%0d winner=%0d p1=%0d p2=%0d, expected 0 0 0 0 240 240",
                     state, p1_score, p2_score, winner, p1_pos, p2_pos);
        end
    endtask

    task automatic test_win();
        model_new_match();
        start = 1'b1;
        idle(3);
        for (int pt = 0; pt < 10; pt++) begin
            play_point(1, 1'b0);
        end
        checks++;
        if ({state, winner, p1_score} !== {2'd3, 2'd1, 4'd10}) begin
            errors++;
            $display("[TB] FAIL p1_wins: state=%0d winner=%0d s1=%0d, expected 3 1 10",
                     state, winner, p1_score);
        end
    endtask

    task automatic test_reset_midgame();
        start = 1'b0;
        idle(3);
        model_new_match();
        start = 1'b1;
        idle(3);
        play_point(0, 1'b0);
        p2_dn = 1'b1;
        idle(3);
        repeat (5) begin
            pulse_tick();
            step();
        end
        checks++;
        if ({p2_pos, p2_score} !== {10'd260, 4'd1}) begin
            errors++;
            $display("[TB] FAIL pre_reset: p2_pos=%0d s2=%0d, expected 260 1", p2_pos, p2_score);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({state, p1_score, p2_score, ball_en, serve, winner, p1_pos, p2_pos} !==
            {2'd0, 8'd0, 2'b00, 2'd0, 10'd240, 10'd240}) begin
            errors++;
            $display("[TB] FAIL reset_mid: state=%0d s1=%0d s2=%0d ball_en=%0d serve=%0d winner=%0d p1=%0d p2=%0d, expected all 0 and 240",
                     state, p1_score, p2_score, ball_en, serve, winner, p1_pos, p2_pos);
        end
        idle(2);
        p2_dn = 1'b0;
        start = 1'b0;
        #2 reset = 1'b0;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_start_serve();
        test_point();
        test_paddles();
        test_abort();
        test_random_game();
        test_win();
        test_reset_midgame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
